// File: rtl/div_restoring8_pkg.sv
// Shared definitions for the restoring divider.
// Holds the FSM state encodings and the default operand width.
package div_restoring8_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/div_restoring8_if.sv
// Start/done handshake and operand/result bus between a requester and the divider.
// The requester drives start and the operands; the divider returns results and status.
interface div_restoring8_if #(
  parameter int WIDTH = div_restoring8_pkg::DEF_WIDTH
) ();

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic             busy;
  logic             done;
  logic             dz;

  modport master (
    output start, a, b,
    input  q, r, busy, done, dz
  );

  modport slave (
    input  start, a, b,
    output q, r, busy, done, dz
  );

endinterface

// File: rtl/div_restoring8_sub_lookahead.sv
// Combinational subtractor d = x - y computed as x + ~y + 1 with generate/propagate lookahead.
// c is the carry-out: 1 means no borrow (x >= y).
module sub_lookahead #(
  parameter int N = 9
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  output logic [N-1:0] d,
  output logic         c
);

  logic [N-1:0] yn_s;
  logic [N-1:0] g_s;
  logic [N-1:0] p_s;
  logic [N:0]   carry_s;

  assign yn_s = ~y;
  assign g_s  = x & yn_s;
  assign p_s  = x ^ yn_s;

  // Each carry is a sum of products: a generate at bit j propagated through bits j+1..i-1,
  // or the fixed carry-in of 1 propagated through every lower bit.
  always_comb begin
    logic pp_s;
    logic ci_s;
    carry_s    = {(N+1){1'b0}};
    carry_s[0] = 1'b1;
    for (int i = 1; i <= N; i++) begin
      pp_s = 1'b1;
      ci_s = 1'b0;
      for (int j = i - 1; j >= 0; j--) begin
        ci_s = ci_s | (g_s[j] & pp_s);
        pp_s = pp_s & p_s[j];
      end
      carry_s[i] = ci_s | pp_s;
    end
  end

  assign d = p_s ^ carry_s[N-1:0];
  assign c = carry_s[N];

endmodule

// File: rtl/div_restoring8.sv
// Multi-cycle unsigned restoring divider: one trial subtraction per cycle, WIDTH iterations.
// Results, busy and the done pulse are all registered outputs.
module div_restoring8
  import div_restoring8_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input logic            clk,
  input logic            rst,
  div_restoring8_if.slave bus
);

  localparam int             CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1'b1);

  state_t           state_r, state_s;
  logic [WIDTH-1:0] rem_r, rem_s;
  logic [WIDTH-1:0] quo_r, quo_s;
  logic [WIDTH-1:0] b_r, b_s;
  logic [CW-1:0]    cnt_r, cnt_s;
  logic             dzp_r, dzp_s;
  logic [WIDTH-1:0] q_r, q_s;
  logic [WIDTH-1:0] r_r, r_s;
  logic             dz_r, dz_s;
  logic             done_r, done_s;
  logic             busy_r, busy_s;

  logic [WIDTH:0]   t_s;
  logic [WIDTH:0]   diff_s;
  logic             carry_s;
  logic             take_s;

  assign t_s = {rem_r, quo_r[WIDTH-1]};

  sub_lookahead #(.N(WIDTH + 1)) u_sub (
    .x (t_s),
    .y ({1'b0, b_r}),
    .d (diff_s),
    .c (carry_s)
  );

  // With no borrow the difference is below b, so its top bit is always clear.
  assign take_s = carry_s & ~diff_s[WIDTH];

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state, datapath and output-register next values.
  always_comb begin
    state_s = state_r;
    rem_s   = rem_r;
    quo_s   = quo_r;
    b_s     = b_r;
    cnt_s   = cnt_r;
    dzp_s   = dzp_r;
    q_s     = q_r;
    r_s     = r_r;
    dz_s    = dz_r;
    done_s  = 1'b0;
    busy_s  = (state_r == S_CALC);
    case (state_r)
      S_IDLE: begin
        if (bus.start) begin
          b_s   = bus.b;
          cnt_s = {CW{1'b0}};
          if (bus.b != {WIDTH{1'b0}}) begin
            rem_s   = {WIDTH{1'b0}};
            quo_s   = bus.a;
            dzp_s   = 1'b0;
            state_s = S_CALC;
          end else begin
            // Divide by zero skips the iterations and reports all-ones / dividend.
            rem_s   = bus.a;
            quo_s   = {WIDTH{1'b1}};
            dzp_s   = 1'b1;
            state_s = S_FIN;
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_CALC: begin
        rem_s = take_s ? diff_s[WIDTH-1:0] : t_s[WIDTH-1:0];
        quo_s = {quo_r[WIDTH-2:0], take_s};
        cnt_s = cnt_r + CNT_ONE;
        if (cnt_r == CNT_LAST) begin
          state_s = S_FIN;
        end else begin
          state_s = S_CALC;
        end
      end
      S_FIN: begin
        q_s     = quo_r;
        r_s     = rem_r;
        dz_s    = dzp_r;
        done_s  = 1'b1;
        state_s = S_IDLE;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_r  <= {WIDTH{1'b0}};
      quo_r  <= {WIDTH{1'b0}};
      b_r    <= {WIDTH{1'b0}};
      cnt_r  <= {CW{1'b0}};
      dzp_r  <= 1'b0;
      q_r    <= {WIDTH{1'b0}};
      r_r    <= {WIDTH{1'b0}};
      dz_r   <= 1'b0;
      done_r <= 1'b0;
      busy_r <= 1'b0;
    end else begin
      rem_r  <= rem_s;
      quo_r  <= quo_s;
      b_r    <= b_s;
      cnt_r  <= cnt_s;
      dzp_r  <= dzp_s;
      q_r    <= q_s;
      r_r    <= r_s;
      dz_r   <= dz_s;
      done_r <= done_s;
      busy_r <= busy_s;
    end
  end

  assign bus.q    = q_r;
  assign bus.r    = r_r;
  assign bus.dz   = dz_r;
  assign bus.done = done_r;
  assign bus.busy = busy_r;

endmodule

// File: tb/tb_div_restoring8.sv
// Directed self-checking bench for div_restoring8 (WIDTH=8).
// Edge 0 is the edge that samples start; outputs are sampled 1 time unit after each edge.
module tb_div_restoring8;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  div_restoring8_if #(.WIDTH(8)) bus ();

  div_restoring8 #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic start_op(input logic [7:0] aa, input logic [7:0] bb, input logic hold);
    bus.a     = aa;
    bus.b     = bb;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) bus.start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) begin
        cyc = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = 8'd0;
    bus.b     = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.q, bus.r, bus.busy, bus.done, bus.dz} !== 19'd0) begin
      errors++;
      $display("FAIL reset_outputs got q=%0d r=%0d busy=%b done=%b dz=%b want all 0",
               bus.q, bus.r, bus.busy, bus.done, bus.dz);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    logic exp_busy;
    logic exp_done;
    start_op(8'd200, 8'd7, 1'b0);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy_c0 got %b want 0", bus.busy);
    end
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      exp_busy = (k <= 8);
      exp_done = (k == 9);
      checks++;
      if ({bus.busy, bus.done} !== {exp_busy, exp_done}) begin
        errors++;
        $display("FAIL basic_timing cycle %0d got busy=%b done=%b want busy=%b done=%b",
                 k, bus.busy, bus.done, exp_busy, exp_done);
      end
    end
    checks++;
    if ({bus.q, bus.r, bus.dz} !== {8'd28, 8'd4, 1'b0}) begin
      errors++;
      $display("FAIL basic_200_7 got q=%0d r=%0d dz=%b want q=28 r=4 dz=0", bus.q, bus.r, bus.dz);
    end
  endtask

  task automatic test_patterns();
    logic [7:0] va [3] = '{8'd255, 8'd5, 8'd0};
    logic [7:0] vb [3] = '{8'd1,   8'd9, 8'd3};
    logic [7:0] eq [3] = '{8'd255, 8'd0, 8'd0};
    logic [7:0] er [3] = '{8'd0,   8'd5, 8'd0};
    int cyc;
    for (int i = 0; i < 3; i++) begin
      start_op(va[i], vb[i], 1'b0);
      if (i == 1) begin
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (bus.q !== 8'd255) begin
          errors++;
          $display("FAIL pattern_hold got q=%0d want 255 while busy", bus.q);
        end
        wait_done(cyc);
        cyc = cyc + 4;
      end else begin
        wait_done(cyc);
      end
      checks++;
      if (cyc !== 9) begin
        errors++;
        $display("FAIL pattern_latency %0d/%0d got %0d want 9", va[i], vb[i], cyc);
      end
      checks++;
      if ({bus.q, bus.r, bus.dz} !== {eq[i], er[i], 1'b0}) begin
        errors++;
        $display("FAIL pattern_result %0d/%0d got q=%0d r=%0d dz=%b want q=%0d r=%0d dz=0",
                 va[i], vb[i], bus.q, bus.r, bus.dz, eq[i], er[i]);
      end
    end
  endtask

  task automatic test_div_zero();
    int cyc;
    start_op(8'd77, 8'd0, 1'b0);
    wait_done(cyc);
    checks++;
    if (cyc !== 1) begin
      errors++;
      $display("FAIL dz_latency got %0d want 1", cyc);
    end
    checks++;
    if ({bus.q, bus.r, bus.dz, bus.busy} !== {8'd255, 8'd77, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL dz_result got q=%0d r=%0d dz=%b busy=%b want q=255 r=77 dz=1 busy=0",
               bus.q, bus.r, bus.dz, bus.busy);
    end
    start_op(8'd10, 8'd3, 1'b0);
    wait_done(cyc);
    checks++;
    if ({bus.q, bus.r, bus.dz} !== {8'd3, 8'd1, 1'b0}) begin
      errors++;
      $display("FAIL dz_clear got q=%0d r=%0d dz=%b want q=3 r=1 dz=0", bus.q, bus.r, bus.dz);
    end
  endtask

  task automatic test_ignore_start();
    int n_done;
    int done_at;
    n_done  = 0;
    done_at = -1;
    start_op(8'd100, 8'd10, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) begin
        n_done++;
        done_at = k;
        checks++;
        if ({bus.q, bus.r} !== {8'd10, 8'd0}) begin
          errors++;
          $display("FAIL ignore_result got q=%0d r=%0d want q=10 r=0", bus.q, bus.r);
        end
      end
      bus.start = (k == 4 || k == 8);
      bus.a     = 8'd9;
      bus.b     = 8'd2;
    end
    bus.start = 1'b0;
    checks++;
    if (n_done !== 1 || done_at !== 9) begin
      errors++;
      $display("FAIL ignore_done got %0d pulses last at %0d want 1 pulse at 9", n_done, done_at);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    logic seen_done;
    start_op(8'd200, 8'd7, 1'b0);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.q, bus.r, bus.busy, bus.done, bus.dz} !== 19'd0) begin
      errors++;
      $display("FAIL midreset_outputs got q=%0d r=%0d busy=%b done=%b dz=%b want all 0",
               bus.q, bus.r, bus.busy, bus.done, bus.dz);
    end
    @(negedge clk);
    rst = 1'b0;
    seen_done = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1 || bus.busy === 1'b1) seen_done = 1'b1;
    end
    checks++;
    if (seen_done !== 1'b0) begin
      errors++;
      $display("FAIL midreset_abandon got activity=%b want 0", seen_done);
    end
    start_op(8'd50, 8'd6, 1'b0);
    wait_done(cyc);
    checks++;
    if ({bus.q, bus.r, cyc} !== {8'd8, 8'd2, 32'sd9}) begin
      errors++;
      $display("FAIL midreset_next got q=%0d r=%0d lat=%0d want q=8 r=2 lat=9", bus.q, bus.r, cyc);
    end
  endtask

  task automatic test_back_to_back();
    int d1;
    int d2;
    d1 = -1;
    d2 = -1;
    start_op(8'd60, 8'd7, 1'b1);
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) begin
        if (d1 < 0) d1 = k;
        else d2 = k;
        checks++;
        if ({bus.q, bus.r, bus.dz} !== {8'd8, 8'd4, 1'b0}) begin
          errors++;
          $display("FAIL b2b_result cycle %0d got q=%0d r=%0d dz=%b want q=8 r=4 dz=0",
                   k, bus.q, bus.r, bus.dz);
        end
      end
      if (k == 10) bus.start = 1'b0;
    end
    checks++;
    if (d1 !== 9 || d2 !== 19) begin
      errors++;
      $display("FAIL b2b_spacing got done at %0d and %0d want 9 and 19", d1, d2);
    end
  endtask

  task automatic test_sweep();
    logic [7:0] aa;
    logic [7:0] bb;
    logic [7:0] eq;
    logic [7:0] er;
    logic       ed;
    int cyc;
    for (int i = 0; i < 20; i++) begin
      aa = 8'($urandom_range(0, 255));
      bb = (i == 5) ? 8'd0 : 8'($urandom_range(0, 255));
      if (bb == 8'd0) begin
        eq = 8'd255;
        er = aa;
        ed = 1'b1;
      end else begin
        eq = aa / bb;
        er = aa % bb;
        ed = 1'b0;
      end
      start_op(aa, bb, 1'b0);
      wait_done(cyc);
      checks++;
      if ({bus.q, bus.r, bus.dz} !== {eq, er, ed}) begin
        errors++;
        $display("FAIL sweep %0d/%0d got q=%0d r=%0d dz=%b want q=%0d r=%0d dz=%b",
                 aa, bb, bus.q, bus.r, bus.dz, eq, er, ed);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_patterns();
    test_div_zero();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
